// File: rtl/cpu_ctrl_fsm.sv
// Multicycle control unit for cpu_01: one state per cycle, decodes the IR opcode,
// drives the ctrl_sig_t bundle, resolves branches on the registered flags and counts retires.
package defs_pkg;
  typedef enum logic [3:0] {
    OPCODE_LI, OPCODE_ADDI, OPCODE_LW, OPCODE_SW,
    OPCODE_ADD, OPCODE_SUB, OPCODE_AND, OPCODE_OR,
    OPCODE_XOR, OPCODE_SLL, OPCODE_SRL, OPCODE_SRA,
    OPCODE_LINK, OPCODE_JMP, OPCODE_JPR, OPCODE_BRH
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_opcode_t;

  typedef enum logic [3:0] {
    STATE_FETCH, STATE_DECODE, STATE_WB_LI, STATE_EXEC_ADDI,
    STATE_WB_ADDI, STATE_EXEC_LW, STATE_MEM_LW, STATE_WB_LW,
    STATE_EXEC_SW, STATE_MEM_SW, STATE_EXEC_ALU, STATE_WB_ALU,
    STATE_EXEC_LINK, STATE_EXEC_JMP, STATE_EXEC_JPR, STATE_EXEC_BRH
  } state_t;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } alu_flags_t;

  typedef struct packed {
    logic       ROM_read;
    logic       IR_load;
    logic       PC_write;
    logic       PC_sel;
    logic [1:0] ADDER_sel;
    logic       AB_load;
    logic       REG2_sel;
    logic       RF_write;
    logic [2:0] REGW_sel;
    logic [3:0] ALU_op;
    logic       ALU_sel;
    logic       ACC_load;
    logic       FLAG_load;
    logic       MAR_load;
    logic       MEM_read;
    logic       MDR_load;
    logic       MEM_write;
  } ctrl_sig_t;
endpackage

module cpu_ctrl_fsm
  import defs_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [INSTR_W-1:0] instr,
  input  logic [3:0]         flags,
  input  logic               mem_ready,
  output ctrl_sig_t          ctrl,
  output state_t             state,
  output logic               instr_done,
  output logic [CNT_W-1:0]   instr_count
);

  state_t           state_q, state_d;
  ctrl_sig_t        ctrl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_raw;
  opcode_t          opc;
  logic [2:0]       cond;
  alu_flags_t       fl;
  logic             br_flag, br_taken;
  logic             unused_instr;

  assign op_raw       = instr[INSTR_W-1 -: 4];
  assign opc          = opcode_t'(op_raw);
  assign cond         = instr[INSTR_W-5 -: 3];
  assign fl           = alu_flags_t'(flags);
  assign unused_instr = ^instr[INSTR_W-8:0];

  always_comb begin
    br_flag = fl.zero;
    case (cond[2:1])
      2'd0: br_flag = fl.zero;
      2'd1: br_flag = fl.negative;
      2'd2: br_flag = fl.carry;
      2'd3: br_flag = fl.overflow;
      default: br_flag = fl.zero;
    endcase
    br_taken = br_flag ^ cond[0];
  end

  always_comb begin
    state_d = state_q;
    ctrl_d  = '0;
    case (state_q)
      STATE_FETCH: if (run) begin
        ctrl_d.ROM_read = 1'b1;
        ctrl_d.IR_load  = 1'b1;
        ctrl_d.PC_write = 1'b1;
        state_d         = STATE_DECODE;
      end
      STATE_DECODE: begin
        ctrl_d.AB_load  = 1'b1;
        ctrl_d.REG2_sel = (opc == OPCODE_SW);
        case (opc)
          OPCODE_LI:   state_d = STATE_WB_LI;
          OPCODE_ADDI: state_d = STATE_EXEC_ADDI;
          OPCODE_LW:   state_d = STATE_EXEC_LW;
          OPCODE_SW:   state_d = STATE_EXEC_SW;
          OPCODE_LINK: state_d = STATE_EXEC_LINK;
          OPCODE_JMP:  state_d = STATE_EXEC_JMP;
          OPCODE_JPR:  state_d = STATE_EXEC_JPR;
          OPCODE_BRH:  state_d = STATE_EXEC_BRH;
          default:     state_d = STATE_EXEC_ALU;
        endcase
      end
      STATE_WB_LI: begin
        ctrl_d.RF_write = 1'b1;
        ctrl_d.REGW_sel = 3'b010;
        state_d         = STATE_FETCH;
      end
      STATE_EXEC_ADDI: begin
        ctrl_d.ALU_op    = {1'b0, ALU_ADD};
        ctrl_d.ALU_sel   = 1'b1;
        ctrl_d.ACC_load  = 1'b1;
        ctrl_d.FLAG_load = 1'b1;
        state_d          = STATE_WB_ADDI;
      end
      STATE_WB_ADDI, STATE_WB_ALU: begin
        ctrl_d.RF_write = 1'b1;
        state_d         = STATE_FETCH;
      end
      STATE_EXEC_LW: begin
        ctrl_d.MAR_load  = 1'b1;
        ctrl_d.ADDER_sel = 2'b10;
        state_d          = STATE_MEM_LW;
      end
      STATE_MEM_LW: begin
        ctrl_d.MEM_read = 1'b1;
        ctrl_d.MDR_load = mem_ready;
        if (mem_ready) state_d = STATE_WB_LW;
      end
      STATE_WB_LW: begin
        ctrl_d.RF_write = 1'b1;
        ctrl_d.REGW_sel = 3'b001;
        state_d         = STATE_FETCH;
      end
      STATE_EXEC_SW: begin
        ctrl_d.MAR_load  = 1'b1;
        ctrl_d.ADDER_sel = 2'b10;
        ctrl_d.REG2_sel  = 1'b1;
        state_d          = STATE_MEM_SW;
      end
      STATE_MEM_SW: begin
        ctrl_d.MEM_write = 1'b1;
        ctrl_d.REG2_sel  = 1'b1;
        if (mem_ready) state_d = STATE_FETCH;
      end
      STATE_EXEC_ALU: begin
        // ALU opcodes follow the register-register opcodes in the same order, offset by 4
        ctrl_d.ALU_op    = {1'b0, 3'(op_raw[2:0] - 3'd4)};
        ctrl_d.ACC_load  = 1'b1;
        ctrl_d.FLAG_load = 1'b1;
        state_d          = STATE_WB_ALU;
      end
      STATE_EXEC_LINK: begin
        ctrl_d.RF_write = 1'b1;
        ctrl_d.REGW_sel = 3'b100;
        state_d         = STATE_FETCH;
      end
      STATE_EXEC_JMP, STATE_EXEC_JPR: begin
        ctrl_d.PC_write  = 1'b1;
        ctrl_d.PC_sel    = 1'b1;
        ctrl_d.ADDER_sel = (state_q == STATE_EXEC_JMP) ? 2'b01 : 2'b11;
        state_d          = STATE_FETCH;
      end
      STATE_EXEC_BRH: begin
        if (br_taken) begin
          ctrl_d.PC_write  = 1'b1;
          ctrl_d.PC_sel    = 1'b1;
          ctrl_d.ADDER_sel = 2'b01;
        end
        state_d = STATE_FETCH;
      end
      default: state_d = STATE_FETCH;
    endcase
  end

  // Outputs are gated by rst_n so nothing leaks while reset is held
  assign ctrl        = rst_n ? ctrl_d : '0;
  assign instr_done  = rst_n && (state_q != STATE_FETCH) && (state_d == STATE_FETCH);
  assign state       = state_q;
  assign instr_count = cnt_q;
  assign cnt_d       = instr_done ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STATE_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm with CNT_W=4 so the retire counter wrap is reachable.
module tb_cpu_ctrl_fsm;
  import defs_pkg::*;

  logic       clk, rst_n, run, mem_ready, instr_done;
  logic [15:0] instr;
  logic [3:0] flags, instr_count;
  ctrl_sig_t  ctrl, e;
  state_t     state;
  int         nerr, nchk;

  cpu_ctrl_fsm #(.INSTR_W(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .flags(flags),
    .mem_ready(mem_ready), .ctrl(ctrl), .state(state),
    .instr_done(instr_done), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Three-cycle instruction: FETCH, DECODE, then the single execute/write-back state
  task automatic x3(input string tag, input logic [15:0] ins, input ctrl_sig_t exp_c);
    instr = ins;
    step();
    step();
    chk({tag, "_ctrl"}, 32'(ctrl), 32'(exp_c));
    chk({tag, "_done"}, 32'(instr_done), 32'd1);
    step();
  endtask

  initial begin
    nerr = 0; nchk = 0;
    rst_n = 1'b0; run = 1'b1; instr = '0; flags = '0; mem_ready = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'(STATE_FETCH));
    chk("rst_ctrl", 32'(ctrl), 32'd0);
    chk("rst_done", 32'(instr_done), 32'd0);
    chk("rst_cnt", 32'(instr_count), 32'd0);

    run = 1'b0;
    step(); step();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("idle_state", 32'(state), 32'(STATE_FETCH));
      chk("idle_rom", 32'(ctrl.ROM_read), 32'd0);
      chk("idle_cnt", 32'(instr_count), 32'd0);
      step();
    end

    // ADD
    run = 1'b1; instr = 16'h4123;
    #1;
    e = '0; e.ROM_read = 1'b1; e.IR_load = 1'b1; e.PC_write = 1'b1;
    chk("fetch_ctrl", 32'(ctrl), 32'(e));
    step();
    chk("add_dec_state", 32'(state), 32'(STATE_DECODE));
    e = '0; e.AB_load = 1'b1;
    chk("add_dec_ctrl", 32'(ctrl), 32'(e));
    step();
    chk("add_exec_state", 32'(state), 32'(STATE_EXEC_ALU));
    e = '0; e.ACC_load = 1'b1; e.FLAG_load = 1'b1;
    chk("add_exec_ctrl", 32'(ctrl), 32'(e));
    chk("add_exec_done", 32'(instr_done), 32'd0);
    step();
    chk("add_wb_state", 32'(state), 32'(STATE_WB_ALU));
    e = '0; e.RF_write = 1'b1;
    chk("add_wb_ctrl", 32'(ctrl), 32'(e));
    chk("add_wb_done", 32'(instr_done), 32'd1);
    step();
    chk("add_ret_state", 32'(state), 32'(STATE_FETCH));
    chk("add_ret_done", 32'(instr_done), 32'd0);
    chk("add_cnt", 32'(instr_count), 32'd1);

    // SRA maps to ALU_op 0111
    instr = 16'hB000;
    step(); step();
    chk("sra_aluop", 32'(ctrl.ALU_op), 32'h7);
    step(); step();
    chk("sra_cnt", 32'(instr_count), 32'd2);

    // LW with two wait cycles
    instr = 16'h2000;
    step(); step();
    e = '0; e.MAR_load = 1'b1; e.ADDER_sel = 2'b10;
    chk("lw_exec_ctrl", 32'(ctrl), 32'(e));
    for (int i = 0; i < 2; i++) begin
      step();
      chk("lw_wait_state", 32'(state), 32'(STATE_MEM_LW));
      chk("lw_wait_rd", 32'(ctrl.MEM_read), 32'd1);
      chk("lw_wait_mdr", 32'(ctrl.MDR_load), 32'd0);
    end
    step();
    mem_ready = 1'b1;
    #1;
    chk("lw_rdy_rd", 32'(ctrl.MEM_read), 32'd1);
    chk("lw_rdy_mdr", 32'(ctrl.MDR_load), 32'd1);
    chk("lw_rdy_done", 32'(instr_done), 32'd0);
    step();
    mem_ready = 1'b0;
    #1;
    chk("lw_wb_state", 32'(state), 32'(STATE_WB_LW));
    e = '0; e.RF_write = 1'b1; e.REGW_sel = 3'b001;
    chk("lw_wb_ctrl", 32'(ctrl), 32'(e));
    chk("lw_wb_done", 32'(instr_done), 32'd1);
    step();
    chk("lw_cnt", 32'(instr_count), 32'd3);

    // Branches
    e = '0; e.PC_write = 1'b1; e.PC_sel = 1'b1; e.ADDER_sel = 2'b01;
    flags = 4'b1000; x3("brh_z_tk", 16'hF000, e);
    flags = 4'b0000; x3("brh_z_nt", 16'hF000, '0);
    flags = 4'b0000; x3("brh_nz_tk", 16'hF200, e);
    flags = 4'b0010; x3("brh_nc_nt", 16'hFA00, '0);
    flags = 4'b0100; x3("brh_n_tk", 16'hF400, e);
    chk("brh_cnt", 32'(instr_count), 32'd8);

    // SW interrupted by reset while waiting on memory
    instr = 16'h3000;
    step();
    e = '0; e.AB_load = 1'b1; e.REG2_sel = 1'b1;
    chk("sw_dec_ctrl", 32'(ctrl), 32'(e));
    step();
    e = '0; e.MAR_load = 1'b1; e.ADDER_sel = 2'b10; e.REG2_sel = 1'b1;
    chk("sw_exec_ctrl", 32'(ctrl), 32'(e));
    step(); step();
    e = '0; e.MEM_write = 1'b1; e.REG2_sel = 1'b1;
    chk("sw_wait_state", 32'(state), 32'(STATE_MEM_SW));
    chk("sw_wait_ctrl", 32'(ctrl), 32'(e));
    rst_n = 1'b0;
    #1;
    chk("sw_rst_ctrl", 32'(ctrl), 32'd0);
    chk("sw_rst_state", 32'(state), 32'(STATE_FETCH));
    chk("sw_rst_cnt", 32'(instr_count), 32'd0);
    chk("sw_rst_done", 32'(instr_done), 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("sw_rel_state", 32'(state), 32'(STATE_FETCH));
    chk("sw_rel_cnt", 32'(instr_count), 32'd0);

    // SW with memory ready early; ready outside MEM_SW must not matter
    mem_ready = 1'b1;
    step(); step(); step();
    chk("sw_mem_state", 32'(state), 32'(STATE_MEM_SW));
    chk("sw_mem_done", 32'(instr_done), 32'd1);
    step();
    mem_ready = 1'b0;
    chk("sw_cnt", 32'(instr_count), 32'd1);

    // ADDI with run dropped mid-instruction
    instr = 16'h1000;
    step();
    run = 1'b0;
    step();
    e = '0; e.ALU_sel = 1'b1; e.ACC_load = 1'b1; e.FLAG_load = 1'b1;
    chk("addi_exec_ctrl", 32'(ctrl), 32'(e));
    step();
    e = '0; e.RF_write = 1'b1;
    chk("addi_wb_ctrl", 32'(ctrl), 32'(e));
    step();
    chk("addi_cnt", 32'(instr_count), 32'd2);
    chk("addi_hold_rom", 32'(ctrl.ROM_read), 32'd0);
    step();
    chk("addi_hold_state", 32'(state), 32'(STATE_FETCH));
    run = 1'b1;

    e = '0; e.RF_write = 1'b1; e.REGW_sel = 3'b010;
    x3("li", 16'h0000, e);
    e = '0; e.RF_write = 1'b1; e.REGW_sel = 3'b100;
    x3("link", 16'hC000, e);
    e = '0; e.PC_write = 1'b1; e.PC_sel = 1'b1; e.ADDER_sel = 2'b01;
    x3("jmp", 16'hD000, e);
    e.ADDER_sel = 2'b11;
    x3("jpr", 16'hE000, e);
    chk("jpr_cnt", 32'(instr_count), 32'd6);

    // Counter wrap
    instr = 16'h0000;
    for (int i = 0; i < 9; i++) begin
      step(); step(); step();
    end
    chk("cnt_15", 32'(instr_count), 32'd15);
    step(); step(); step();
    chk("cnt_wrap", 32'(instr_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
